// File: rtl/arb_request_agent.sv
// Requester-side front end for the daisy-chain arbiter. Start pulses become held requests, and a granted client locks the bus for a counted burst.
// The optional starvation timeout is enabled by defining ARB_REQUEST_AGENT_TIMEOUT_EN, which also adds the starve_o port.
module arb_request_agent #(
  parameter int N       = 8,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:N-1]      start,
  input  logic [0:N*LENW-1] len,
  output logic [0:N-1]      req_o,
  input  logic [0:N-1]      gnt_i,
  output logic [0:N-1]      own_o,
  output logic [0:N-1]      busy_o,
  output logic [0:N-1]      done_o,
  output logic              gnt_err_o
`ifdef ARB_REQUEST_AGENT_TIMEOUT_EN
  ,
  output logic [0:N-1]      starve_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, OWN} state_t;

  state_t          state_q [N];
  state_t          state_d [N];
  logic [LENW-1:0] cnt_q   [N];
  logic [LENW-1:0] cnt_d   [N];
  logic            lock_q, lock_d;
  logic [0:N-1]    done_q, done_d;
  logic [0:N-1]    take;      // one-hot: the client accepting the grant this cycle
  logic [0:N-1]    eligible;  // request mask; all ones unless starvation overrides
  logic            grant_seen, grant_multi;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("arb_request_agent: TIMEOUT must be at least 1");
  end

`ifdef ARB_REQUEST_AGENT_TIMEOUT_EN
  localparam int            WW   = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  logic [WW-1:0] wait_q [N];
  logic [0:N-1]  starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (state_q[i] != REQ || take[i]) wait_q[i] <= '0;
        else if (wait_q[i] != WMAX)       wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) starved[i] = (wait_q[i] == WMAX);
  end

  // Starved clients hide everyone else, so the chain picks the lowest starved index.
  assign eligible = (|starved) ? starved : '1;
  assign starve_o = starved;
`else
  assign eligible = '1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the whole per-client state, including the burst counters, is reset so a reset mid-burst leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q <= 1'b0;
      done_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      lock_q <= lock_d;
      done_q <= done_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Grant decode: take the lowest requesting grant bit, and flag stray or multiple grants.
  always_comb begin
    take        = '0;
    grant_seen  = 1'b0;
    grant_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_o[i] && gnt_i[i]) begin
        if (grant_seen) grant_multi = 1'b1;
        else            take[i]     = 1'b1;
        grant_seen = 1'b1;
      end
    end
    gnt_err_o = grant_multi || (|(gnt_i & ~req_o));
  end

  // NOTE: every combinational output is given a default first, so no path can infer a latch.
  always_comb begin
    lock_d = lock_q;
    done_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: if (start[i]) begin
          state_d[i] = REQ;
          cnt_d[i]   = len[i*LENW +: LENW];
        end
        REQ: if (take[i]) begin
          state_d[i] = OWN;
          lock_d     = 1'b1;
        end
        OWN: if (cnt_q[i] == '0) begin
          state_d[i] = IDLE;
          lock_d     = 1'b0;
          done_d[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // req_o comes only from registered state, so it has no path back from gnt_i.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_o[i]  = (state_q[i] == REQ) && !lock_q && eligible[i];
      own_o[i]  = (state_q[i] == OWN);
      busy_o[i] = (state_q[i] != IDLE);
    end
  end

  assign done_o = done_q;

endmodule
